fft_addr_gen: RTL and testbench
===============================

Name: fft_addr_gen

Overview:
- Butterfly address scheduler for the in-place radix-2 DIT FFT.
- On each go it walks all N/2 butterflies of the current level and issues one butterfly per cycle to the ping-pong BRAM pair: read address pair A/B plus twiddle ROM address.
- It replays the same address pair as the write-back address BFLY_LATENCY cycles later.
- Sequenced by the top-level FFT controller: go/busy for the read sweep, fft_data_valid for the write drain.

Parameters:
- FFT_SIZE, 4096: points N; power of two, >= 4.
- LEVELS, $clog2(FFT_SIZE): number of FFT stages.
- BFLY_LATENCY, 6: cycles from rd_en to the matching wr_en. Must be >= 1.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- addr_gen_go  in  1  single-cycle start pulse for one level
- fft_level  in  $clog2(LEVELS)  current stage s; held stable from the cycle after go until busy falls
- addr_gen_busy  out  1  read sweep in progress
- rd_en  out  1  read strobe, both banks
- rd_addr_a  out  $clog2(FFT_SIZE)  top butterfly input address
- rd_addr_b  out  $clog2(FFT_SIZE)  bottom butterfly input address
- tw_addr  out  $clog2(FFT_SIZE)-1  twiddle ROM index
- wr_en  out  1  write strobe (drives fft_data_valid)
- wr_addr_a  out  $clog2(FFT_SIZE)  write-back address for result A
- wr_addr_b  out  $clog2(FFT_SIZE)  write-back address for result B

Behaviour:
- Reset (async, active-high): all outputs 0, state IDLE, butterfly counter k=0, delay line cleared.
- States: IDLE, RUN.
  - IDLE -> RUN on addr_gen_go.
  - RUN -> IDLE when k==N/2-1 is issued.
- addr_gen_go while in RUN is ignored.
- fft_level is not latched at go; the controller updates it on the same edge as go. It is read combinationally during RUN.
- RUN, per cycle, with h = 2^s:
  - rd_en=1.
  - pos = k & (h-1); grp = k >> s.
  - rd_addr_a = (grp << (s+1)) | pos.
  - rd_addr_b = rd_addr_a + h.
  - tw_addr = pos << (LEVELS-1-s), truncated to tw_addr width.
  - k increments by 1 each cycle.
- Read outputs are registered: go sampled at edge E0 -> first rd_en visible after E0; exactly N/2 consecutive rd_en cycles; no gaps.
- addr_gen_busy = (state==RUN). It is coincident with rd_en: high for exactly N/2 cycles, and low in the cycle after the last read.
- In IDLE: rd_en=0; rd_addr_a, rd_addr_b and tw_addr hold their last values.
- Write side:
  - {rd_en, rd_addr_a, rd_addr_b} passes through a BFLY_LATENCY-deep shift register to {wr_en, wr_addr_a, wr_addr_b}.
  - The shift register runs regardless of state, so the drain continues after busy falls.
  - wr_en stays high exactly N/2 cycles per level.
- Back-to-back levels: a go issued while the previous level's writes are still draining is legal. The new reads are issued while the old writes complete, and each path (reads, writes) keeps its own addresses.
- Reset mid-sweep: state returns to IDLE and the delay line is flushed; no wr_en follows the reset.
- Counter k is $clog2(FFT_SIZE)-1 bits wide; it wraps to 0 on the last butterfly.

Optional Feature:
- Macro: FFT_ADDR_GEN_BITREV_EN.
- With the macro defined and s==0: rd_addr_a and rd_addr_b are output bit-reversed (all $clog2(FFT_SIZE) bits). This lets input samples stay in natural order as stored by the AXIS slave. Write addresses remain natural order.
- Without the macro: no reversal; the input must already be bit-reversed in memory.
- Levels s>0 are unaffected in both cases.

Test Plan (FFT_SIZE=16, LEVELS=4, BFLY_LATENCY=6 unless stated):
- Level 0, go pulse -> rd_en high for 8 cycles; (a,b,tw) = (0,1,0), (2,3,0), ..., (14,15,0); busy high for the same 8 cycles.
- Level 1 -> first four issues (0,2,0), (1,3,4), (4,6,0), (5,7,4).
- Level 3 -> k=5 issues (5,13,5); k=7 issues (7,15,7).
- Write drain:
  - First wr_en appears exactly 6 cycles after the first rd_en, with wr_addr_a/b = 0/1 for level 0.
  - wr_en is high for 8 cycles and still active after busy falls.
  - Second go issued while writes are draining -> new reads are correct and the old writes are uncorrupted.
- Assert reset at k=3 of level 2 -> all outputs 0 asynchronously; no wr_en afterwards; the next go restarts at k=0.
- With FFT_ADDR_GEN_BITREV_EN defined, level 0, k=1 -> reads (4,12); wr_addr stays (2,3).

Source files
------------

// File: rtl/fft_addr_gen.sv
// fft_addr_gen: butterfly address scheduler for an in-place radix-2 DIT FFT.
// Each go walks the N/2 butterflies of one level, one per cycle, and issues the
// read pair plus twiddle index. The same pair is replayed as the write-back
// address BFLY_LATENCY cycles later.
// Optional build macro FFT_ADDR_GEN_BITREV_EN: bit-reverse the level-0 read
// addresses so that natural-order input needs no reordering in memory.
module fft_addr_gen #(
    parameter int unsigned FFT_SIZE     = 4096,
    parameter int unsigned LEVELS       = $clog2(FFT_SIZE),
    parameter int unsigned BFLY_LATENCY = 6
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          addr_gen_go,
    input  logic [$clog2(LEVELS)-1:0]     fft_level,
    output logic                          addr_gen_busy,
    output logic                          rd_en,
    output logic [$clog2(FFT_SIZE)-1:0]   rd_addr_a,
    output logic [$clog2(FFT_SIZE)-1:0]   rd_addr_b,
    output logic [$clog2(FFT_SIZE)-2:0]   tw_addr,
    output logic                          wr_en,
    output logic [$clog2(FFT_SIZE)-1:0]   wr_addr_a,
    output logic [$clog2(FFT_SIZE)-1:0]   wr_addr_b
);

    localparam int unsigned AW = $clog2(FFT_SIZE);
    localparam int unsigned KW = AW - 1;
    localparam logic [KW-1:0] K_LAST = KW'(FFT_SIZE / 2 - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [KW-1:0]   k_q;

    // Last issued values, shown on the read port while idle
    logic [AW-1:0]   last_a_q;
    logic [AW-1:0]   last_b_q;
    logic [KW-1:0]   last_tw_q;
    logic [AW-1:0]   last_nat_a_q;
    logic [AW-1:0]   last_nat_b_q;

    int unsigned     lvl;
    logic [AW-1:0]   k_ext;
    logic [AW-1:0]   pos;
    logic [AW-1:0]   nat_a;
    logic [AW-1:0]   nat_b;
    logic [KW-1:0]   tw_nat;
    logic [AW-1:0]   wr_src_a;
    logic [AW-1:0]   wr_src_b;

    logic            pipe_en_q [BFLY_LATENCY];
    logic [AW-1:0]   pipe_a_q  [BFLY_LATENCY];
    logic [AW-1:0]   pipe_b_q  [BFLY_LATENCY];

`ifdef FFT_ADDR_GEN_BITREV_EN
    function automatic logic [AW-1:0] bit_reverse(input logic [AW-1:0] x);
        logic [AW-1:0] r;
        for (int unsigned i = 0; i < AW; i++) begin
            r[i] = x[AW-1-i];
        end
        return r;
    endfunction
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: go is only honoured in IDLE, sweep ends on the last butterfly
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (addr_gen_go) state_d = RUN;
            RUN:     if (k_q == K_LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Butterfly address decode: insert a zero at bit s of k to form the top index
    always_comb begin
        lvl    = 32'(fft_level);
        k_ext  = AW'(k_q);
        pos    = k_ext & ((AW'(1) << lvl) - AW'(1));
        nat_a  = ((k_ext >> lvl) << (lvl + 32'd1)) | pos;
        nat_b  = nat_a + (AW'(1) << lvl);
        tw_nat = KW'(pos << (LEVELS - 32'd1 - lvl));
    end

    // Output decode; the level is read live because the controller updates it on the go edge
    always_comb begin
        addr_gen_busy = 1'b0;
        rd_en         = 1'b0;
        rd_addr_a     = last_a_q;
        rd_addr_b     = last_b_q;
        tw_addr       = last_tw_q;
        wr_src_a      = last_nat_a_q;
        wr_src_b      = last_nat_b_q;
        if (state_q == RUN) begin
            addr_gen_busy = 1'b1;
            rd_en         = 1'b1;
            rd_addr_a     = nat_a;
            rd_addr_b     = nat_b;
            tw_addr       = tw_nat;
            wr_src_a      = nat_a;
            wr_src_b      = nat_b;
`ifdef FFT_ADDR_GEN_BITREV_EN
            if (lvl == 32'd0) begin
                rd_addr_a = bit_reverse(nat_a);
                rd_addr_b = bit_reverse(nat_b);
            end
`endif
        end
    end

    // Butterfly counter and hold registers for the idle read port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            k_q          <= '0;
            last_a_q     <= '0;
            last_b_q     <= '0;
            last_tw_q    <= '0;
            last_nat_a_q <= '0;
            last_nat_b_q <= '0;
        end else if (state_q == RUN) begin
            k_q          <= (k_q == K_LAST) ? '0 : k_q + KW'(1);
            last_a_q     <= rd_addr_a;
            last_b_q     <= rd_addr_b;
            last_tw_q    <= tw_addr;
            last_nat_a_q <= nat_a;
            last_nat_b_q <= nat_b;
        end
    end

    // Write-back delay line; free-running so the drain outlives the read sweep
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < BFLY_LATENCY; i++) begin
                pipe_en_q[i] <= 1'b0;
                pipe_a_q[i]  <= '0;
                pipe_b_q[i]  <= '0;
            end
        end else begin
            pipe_en_q[0] <= rd_en;
            pipe_a_q[0]  <= wr_src_a;
            pipe_b_q[0]  <= wr_src_b;
            for (int unsigned i = 1; i < BFLY_LATENCY; i++) begin
                pipe_en_q[i] <= pipe_en_q[i-1];
                pipe_a_q[i]  <= pipe_a_q[i-1];
                pipe_b_q[i]  <= pipe_b_q[i-1];
            end
        end
    end

    assign wr_en     = pipe_en_q[BFLY_LATENCY-1];
    assign wr_addr_a = pipe_a_q[BFLY_LATENCY-1];
    assign wr_addr_b = pipe_b_q[BFLY_LATENCY-1];

endmodule

// File: tb/tb_fft_addr_gen.sv
// Directed bench for fft_addr_gen at N=16, latency 6.
`timescale 1ns/1ps
module tb_fft_addr_gen;

    localparam int unsigned N   = 16;
    localparam int unsigned LV  = 4;
    localparam int unsigned LAT = 6;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       addr_gen_go = 1'b0;
    logic [1:0] fft_level = 2'd0;
    logic       addr_gen_busy;
    logic       rd_en;
    logic [3:0] rd_addr_a;
    logic [3:0] rd_addr_b;
    logic [2:0] tw_addr;
    logic       wr_en;
    logic [3:0] wr_addr_a;
    logic [3:0] wr_addr_b;

    fft_addr_gen #(
        .FFT_SIZE    (N),
        .LEVELS      (LV),
        .BFLY_LATENCY(LAT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .addr_gen_go  (addr_gen_go),
        .fft_level    (fft_level),
        .addr_gen_busy(addr_gen_busy),
        .rd_en        (rd_en),
        .rd_addr_a    (rd_addr_a),
        .rd_addr_b    (rd_addr_b),
        .tw_addr      (tw_addr),
        .wr_en        (wr_en),
        .wr_addr_a    (wr_addr_a),
        .wr_addr_b    (wr_addr_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned lvl;
        int unsigned k;
        int unsigned ra;
        int unsigned rb;
        int unsigned tw;
        int unsigned wa;
        int unsigned wb;
    } vec_t;

    typedef struct {
        int unsigned due;
        int unsigned a;
        int unsigned b;
    } wexp_t;

    vec_t        vecs[$];
    wexp_t       wq[$];
    int unsigned cyc = 0;
    int          errors = 0;
    int          checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void add(input int unsigned lvl, input int unsigned k,
                                input int unsigned ra, input int unsigned rb,
                                input int unsigned tw, input int unsigned wa,
                                input int unsigned wb);
        vec_t v;
        v.lvl = lvl; v.k = k; v.ra = ra; v.rb = rb; v.tw = tw; v.wa = wa; v.wb = wb;
        vecs.push_back(v);
    endfunction

    // Write-side scoreboard: every cycle wr_en must match the scheduled drain
    always @(negedge clk) begin
        if (wq.size() > 0 && wq[0].due == cyc) begin
            check("wr_en", 32'(wr_en), 32'd1);
            check("wr_addr_a", 32'(wr_addr_a), wq[0].a);
            check("wr_addr_b", 32'(wr_addr_b), wq[0].b);
            void'(wq.pop_front());
        end else begin
            check("wr_en idle", 32'(wr_en), 32'd0);
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, " busy"},      32'(addr_gen_busy), 32'd0);
        check({tag, " rd_en"},     32'(rd_en),         32'd0);
        check({tag, " rd_addr_a"}, 32'(rd_addr_a),     32'd0);
        check({tag, " rd_addr_b"}, 32'(rd_addr_b),     32'd0);
        check({tag, " tw_addr"},   32'(tw_addr),       32'd0);
        check({tag, " wr_en"},     32'(wr_en),         32'd0);
        check({tag, " wr_addr_a"}, 32'(wr_addr_a),     32'd0);
        check({tag, " wr_addr_b"}, 32'(wr_addr_b),     32'd0);
    endtask

    // One level sweep; stray_k re-pulses go mid-sweep, abort_k asserts reset after that issue
    task automatic run_level(input int unsigned lvl, input int stray_k, input int abort_k);
        int   idx[$];
        vec_t v;
        foreach (vecs[i]) if (vecs[i].lvl == lvl) idx.push_back(i);
        @(negedge clk);
        fft_level   = 2'(lvl);
        addr_gen_go = 1'b1;
        foreach (idx[j]) begin
            v = vecs[idx[j]];
            @(negedge clk);
            addr_gen_go = (j == stray_k);
            check($sformatf("L%0d k%0d rd_en", lvl, v.k),     32'(rd_en),         32'd1);
            check($sformatf("L%0d k%0d busy", lvl, v.k),      32'(addr_gen_busy), 32'd1);
            check($sformatf("L%0d k%0d rd_addr_a", lvl, v.k), 32'(rd_addr_a),     v.ra);
            check($sformatf("L%0d k%0d rd_addr_b", lvl, v.k), 32'(rd_addr_b),     v.rb);
            check($sformatf("L%0d k%0d tw_addr", lvl, v.k),   32'(tw_addr),       v.tw);
            wq.push_back('{cyc + LAT, v.wa, v.wb});
            if (j == abort_k) begin
                reset = 1'b1;
                wq.delete();
                #1;
                check_all_zero("async reset");
                return;
            end
        end
        @(negedge clk);
        addr_gen_go = 1'b0;
        check($sformatf("L%0d end busy", lvl),      32'(addr_gen_busy), 32'd0);
        check($sformatf("L%0d end rd_en", lvl),     32'(rd_en),         32'd0);
        check($sformatf("L%0d hold rd_addr_a", lvl), 32'(rd_addr_a),    v.ra);
        check($sformatf("L%0d hold rd_addr_b", lvl), 32'(rd_addr_b),    v.rb);
        check($sformatf("L%0d hold tw_addr", lvl),   32'(tw_addr),      v.tw);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // lvl, k, rd_a, rd_b, tw, wr_a, wr_b
`ifdef FFT_ADDR_GEN_BITREV_EN
        add(0, 0,  0,  8, 0,  0,  1);
        add(0, 1,  4, 12, 0,  2,  3);
        add(0, 2,  2, 10, 0,  4,  5);
        add(0, 3,  6, 14, 0,  6,  7);
        add(0, 4,  1,  9, 0,  8,  9);
        add(0, 5,  5, 13, 0, 10, 11);
        add(0, 6,  3, 11, 0, 12, 13);
        add(0, 7,  7, 15, 0, 14, 15);
`else
        add(0, 0,  0,  1, 0,  0,  1);
        add(0, 1,  2,  3, 0,  2,  3);
        add(0, 2,  4,  5, 0,  4,  5);
        add(0, 3,  6,  7, 0,  6,  7);
        add(0, 4,  8,  9, 0,  8,  9);
        add(0, 5, 10, 11, 0, 10, 11);
        add(0, 6, 12, 13, 0, 12, 13);
        add(0, 7, 14, 15, 0, 14, 15);
`endif
        add(1, 0,  0,  2, 0,  0,  2);
        add(1, 1,  1,  3, 4,  1,  3);
        add(1, 2,  4,  6, 0,  4,  6);
        add(1, 3,  5,  7, 4,  5,  7);
        add(1, 4,  8, 10, 0,  8, 10);
        add(1, 5,  9, 11, 4,  9, 11);
        add(1, 6, 12, 14, 0, 12, 14);
        add(1, 7, 13, 15, 4, 13, 15);
        add(2, 0,  0,  4, 0,  0,  4);
        add(2, 1,  1,  5, 2,  1,  5);
        add(2, 2,  2,  6, 4,  2,  6);
        add(2, 3,  3,  7, 6,  3,  7);
        add(2, 4,  8, 12, 0,  8, 12);
        add(2, 5,  9, 13, 2,  9, 13);
        add(2, 6, 10, 14, 4, 10, 14);
        add(2, 7, 11, 15, 6, 11, 15);
        add(3, 0,  0,  8, 0,  0,  8);
        add(3, 1,  1,  9, 1,  1,  9);
        add(3, 2,  2, 10, 2,  2, 10);
        add(3, 3,  3, 11, 3,  3, 11);
        add(3, 4,  4, 12, 4,  4, 12);
        add(3, 5,  5, 13, 5,  5, 13);
        add(3, 6,  6, 14, 6,  6, 14);
        add(3, 7,  7, 15, 7,  7, 15);

        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;

        // Level 0, then level 1 launched while level-0 writes drain (stray go on last issue)
        run_level(0, -1, -1);
        run_level(1, 7, -1);
        // Level 3 with a stray go mid-sweep
        run_level(3, 2, -1);
        repeat (8) @(negedge clk);

        // Reset at k=3 of level 2: no writes may follow
        run_level(2, -1, 3);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check("post-reset busy", 32'(addr_gen_busy), 32'd0);

        // Next go restarts at k=0
        run_level(2, -1, -1);
        repeat (10) @(negedge clk);
        check("write queue drained", 32'(wq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
